// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divided-clock period/high-time meter.
package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int MAX_CNT_DEF = (1 << CNT_W_DEF) - 1;

  // Largest count a w-bit counter may reach before a period is declared lost.
  function automatic int max_count(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/freq_div_meter_if.sv
// Control/result bundle between a meter and its user; the user side drives enable and div_in.
interface freq_div_meter_if
  import freq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             enable;
  logic             div_in;
  logic             edge_rise;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid;
  logic             timeout;

  modport master (
    output enable, div_in,
    input  edge_rise, period_o, high_o, meas_valid, timeout
  );

  modport slave (
    input  enable, div_in,
    output edge_rise, period_o, high_o, meas_valid, timeout
  );
endinterface

// File: rtl/freq_div_meter_edge_sync_det.sv
// Sampling front end: optional 2-flop synchroniser (FREQ_METER_SYNC_EN), history flop and rise detect.
module edge_sync_det (
  input  logic clk,
  input  logic rst_n,
  input  logic div_in,
  output logic s,
  output logic rise,
  output logic edge_rise
);
  logic s_d_q, s_d_d;
  logic edge_rise_q, edge_rise_d;

`ifdef FREQ_METER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = div_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  // div_in is assumed to be generated from clk, so it is used as-is.
  assign s = div_in;
`endif

  always_comb begin
    rise        = s & ~s_d_q;
    s_d_d       = s;
    edge_rise_d = rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d_q       <= 1'b0;
      edge_rise_q <= 1'b0;
    end else begin
      s_d_q       <= s_d_d;
      edge_rise_q <= edge_rise_d;
    end
  end

  assign edge_rise = edge_rise_q;
endmodule

// File: rtl/freq_div_meter.sv
// Measures period and high time of div_in in clk cycles between consecutive rising edges.
// Optional input synchroniser is enabled with the FREQ_METER_SYNC_EN macro.
module freq_div_meter
  import freq_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  freq_div_meter_if.slave      bus
);
  localparam int               CNT_MAX_I = max_count(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic s, rise, edge_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  edge_sync_det u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_in    (bus.div_in),
    .s         (s),
    .rise      (rise),
    .edge_rise (edge_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = WAIT_EDGE;
        WAIT_EDGE: if (rise) state_d = MEASURE;
        MEASURE:   if (!rise && cnt_q == CNT_MAX) state_d = WAIT_EDGE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // A rise always wins over the timeout, so a period of exactly CNT_MAX is still reported.
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!bus.enable) begin
      cnt_d     = '0;
      hcnt_d    = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          if (rise) begin
            cnt_d  = CNT_ONE;
            hcnt_d = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            hcnt_d    = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (s) hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d  = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  assign bus.edge_rise  = edge_rise;
  assign bus.period_o   = period_q;
  assign bus.high_o     = high_q;
  assign bus.meas_valid = valid_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_freq_div_meter.sv
// Randomised bench for freq_div_meter against a timestamp-based reference model.
module tb_freq_div_meter;
  import freq_div_pkg::*;

  localparam int W    = CNT_W_DEF;
  localparam int MAXC = MAX_CNT_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  freq_div_meter_if #(.CNT_W(W)) bus ();

  freq_div_meter #(.CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: measurements are differences of rise timestamps.
  int cyc       = 0;
  int last_rise = -1;
  int high_acc  = 0;
  bit idle      = 1'b1;
  bit s_prev    = 1'b0;
  bit pipe1     = 1'b0;
  bit pipe2     = 1'b0;
  bit e_edge    = 1'b0;
  bit e_valid   = 1'b0;
  bit e_to      = 1'b0;
  int e_period  = 0;
  int e_high    = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit d);
    bit s;
    bit rise;
    if (!r) begin
      pipe1 = 0; pipe2 = 0; s_prev = 0; idle = 1; last_rise = -1; high_acc = 0;
      e_edge = 0; e_valid = 0; e_to = 0; e_period = 0; e_high = 0;
      cyc++;
      return;
    end
`ifdef FREQ_METER_SYNC_EN
    s = pipe2;
    pipe2 = pipe1;
    pipe1 = d;
`else
    s = d;
`endif
    rise    = s && !s_prev;
    s_prev  = s;
    e_edge  = rise;
    e_valid = 0;
    if (!en) begin
      idle = 1; last_rise = -1; e_to = 0;
    end else if (idle) begin
      idle = 0;
    end else if (rise) begin
      if (last_rise >= 0) begin
        e_period = cyc - last_rise;
        e_high   = high_acc;
        e_valid  = 1;
        e_to     = 0;
      end
      last_rise = cyc;
      high_acc  = 1;
    end else if (last_rise >= 0) begin
      if (cyc - last_rise == MAXC) begin
        e_to = 1;
        last_rise = -1;
      end else begin
        high_acc += int'(s);
      end
    end
    cyc++;
  endtask

  task automatic step(input bit r, input bit en, input bit d);
    @(negedge clk);
    rst_n      = r;
    bus.enable = en;
    bus.div_in = d;
    model_step(r, en, d);
    @(posedge clk);
    #1;
    chk("edge_rise",  int'(bus.edge_rise),  int'(e_edge));
    chk("meas_valid", int'(bus.meas_valid), int'(e_valid));
    chk("timeout",    int'(bus.timeout),    int'(e_to));
    chk("period_o",   int'(bus.period_o),   e_period);
    chk("high_o",     int'(bus.high_o),     e_high);
    if (bus.meas_valid)
      $display("meas cycle=%0d period=%0d high=%0d", cyc, bus.period_o, bus.high_o);
  endtask

  task automatic wave(input int p, input int h, input int n, input bit en);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        step(1'b1, en, i < h);
  endtask

  task automatic hold(input bit en, input bit d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, en, d);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.div_in = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    wave(7, 4, 5, 1'b1);
    hold(1'b1, 1'b0, 3);
    wave(2, 1, 8, 1'b1);

    // One rise, then silence long enough to time out; a fresh pattern then clears it.
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b0, 300);
    wave(7, 4, 4, 1'b1);

    wave(7, 4, 3, 1'b1);
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b0, 4);
    wave(7, 4, 3, 1'b1);

    wave(7, 4, 2, 1'b1);
    hold(1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 1'b0);
    wave(7, 4, 3, 1'b1);

    // Longest measurable period, then one cycle too long.
    wave(255, 100, 3, 1'b1);
    wave(256, 20, 2, 1'b1);
    wave(5, 2, 3, 1'b1);

    for (int seg = 0; seg < 40; seg++) begin
      int sel;
      int p;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        hold(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
      end else if (sel == 1) begin
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end else if (sel == 2) begin
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        p = int'($urandom_range(2, 40));
        wave(p, int'($urandom_range(1, p - 1)), int'($urandom_range(1, 4)), 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_div_meter.md
Name: freq_div_meter

Overview:
- Downstream monitor for the fractional clock divider output.
- Samples the divided clock `div_in` in the `clk` domain and counts `clk` cycles between consecutive rising edges (period) and the high time within each period.
- Reports each completed measurement with a one-cycle valid pulse. Used for divider self-check and duty-cycle/ratio verification in-system.

Parameters:
- CNT_W, 8, width of the period/high counters and result outputs; max measurable period is 2^CNT_W-1 cycles.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- enable  input  1  measurement enable; low aborts and idles the block.
- div_in  input  1  divided clock under measurement (sampled as data).
- edge_rise  output  1  one-cycle pulse on each detected rising edge of the sampled div_in.
- period_o  output  CNT_W  last completed period, in clk cycles.
- high_o  output  CNT_W  clk cycles div_in was high within that period.
- meas_valid  output  1  one-cycle pulse when period_o/high_o update.
- timeout  output  1  sticky flag: no rising edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE; counters=0; period_o=0, high_o=0, meas_valid=0, timeout=0, edge_rise=0; edge-detect history flop=0. Reset mid-measurement discards the partial count.
- Sampling: s = div_in (or synchronised copy, see Optional Feature). s_d = s delayed one cycle. rise = s & ~s_d. edge_rise is registered rise (1-cycle latency).
- States: IDLE, WAIT_EDGE, MEASURE.
  - IDLE: enable=1 -> WAIT_EDGE. Counters held at 0.
  - WAIT_EDGE: rise -> MEASURE, cnt<=1, hcnt<=1.
  - MEASURE, rise: period_o<=cnt, high_o<=hcnt, meas_valid<=1, timeout<=0, cnt<=1, hcnt<=1. Stays in MEASURE (back-to-back periods measured continuously).
  - MEASURE, no rise: cnt<=cnt+1; hcnt<=hcnt+1 if s=1.
- Timeout: in MEASURE, no rise and cnt==2^CNT_W-1 -> timeout<=1, no meas_valid, -> WAIT_EDGE. Counters never wrap.
- Simultaneous rise and cnt==max: the rise wins. The measurement is reported and timeout is not set.
- enable=0 in any state: -> IDLE next cycle; partial measurement dropped; meas_valid=0; timeout cleared; period_o/high_o retain the last values.
- Result semantics: div_in with period P and high time H (both in clk cycles, P <= 2^CNT_W-1) yields period_o=P and high_o=H. First valid output comes one full period after the first rise.
- meas_valid is high for exactly one cycle per completed period. It is never asserted on the first rise after WAIT_EDGE.

Optional Feature:
- Macro FREQ_METER_SYNC_EN.
- Defined: div_in passes through a 2-flop synchroniser (reset to 0) before edge detection. All responses are delayed by 2 cycles; counts are unchanged.
- Undefined: div_in is used directly, for div_in generated from the same clk.

Decomposition:
- Package freq_div_pkg:
  - state enum (IDLE, WAIT_EDGE, MEASURE);
  - default CNT_W constant;
  - a max-count helper constant (2^CNT_W-1).
- Sub-module edge_sync_det holds the optional synchroniser, s_d and the rise/edge_rise generation. The FSM and counters stay in freq_div_meter.

Test Plan:
- Repeating 7-cycle pattern on div_in, high 4 / low 3, enable=1 -> after the second rise, meas_valid pulses every 7 cycles with period_o=7, high_o=4.
- div_in toggling every cycle (period 2) -> period_o=2, high_o=1, meas_valid every 2 cycles, edge_rise every 2 cycles.
- div_in stuck low after one rise, CNT_W=8 -> timeout=1 exactly 255 cycles after the rise, no meas_valid. A later 7-cycle pattern clears timeout on the next valid measurement.
- enable dropped mid-period after a 7/4 measurement -> no meas_valid; period_o=7 and high_o=4 held; re-enable needs two rises before the next meas_valid.
- rst_n low for one cycle mid-MEASURE -> all outputs 0 next cycle; measurement restarts from WAIT_EDGE.
- FREQ_METER_SYNC_EN defined, same 7/4 stimulus -> identical values, edge_rise and meas_valid shifted +2 cycles.
